// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage of the pipelined MIPS core:
// default widths, reset/exception vectors, instruction-memory bounds and
// the encoding of where the next PC comes from.
package cpu_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_LO   = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_HI   = 32'h0000_6ffc;
  localparam int unsigned DEF_STEP      = 4;

  // Source selected for the next fetch PC, listed from highest priority down.
  typedef enum logic [2:0] {
    RST   = 3'd0,
    EXC   = 3'd1,
    ERET  = 3'd2,
    REDIR = 3'd3,
    PEND  = 3'd4,
    SEQ   = 3'd5,
    HOLD  = 3'd6
  } next_src_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry holding register for a branch/jump redirect that shows up
// while the fetch stage is stalled. It keeps the most recent target until
// the PC logic consumes it or an exception/ERET throws it away.
module pc_redirect_buf
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_target,
  input  logic             clear,
  output logic             pend_valid,
  output logic [WIDTH-1:0] pend_target
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [0:0] state;

  // Load wins over clear so a newer redirect during the same stall overwrites the old one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pend_target <= '0;
    end else if (load) begin
      state       <= HELD;
      pend_target <= load_target;
    end else if (clear) begin
      state       <= IDLE;
    end
  end

  assign pend_valid = (state == HELD);

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential increment, branch/jump redirect
// with a one-entry stall buffer, exception/ERET override, and a fetch
// address-error flag derived from the current PC.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int unsigned      STEP      = DEF_STEP,
  parameter logic [WIDTH-1:0] IMEM_LO   = WIDTH'(DEF_IMEM_LO),
  parameter logic [WIDTH-1:0] IMEM_HI   = WIDTH'(DEF_IMEM_HI)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             redirect_pending,
  output logic             adel
);

  next_src_e        src;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_target;
  logic             buf_load;
  logic             buf_clear;
  logic [WIDTH-1:0] pc_reg = RESET_VEC;

  // Priority mux: exceptions and ERET ignore the stall, everything else waits for en.
  always_comb begin
    src = HOLD;
    if (reset)                     src = RST;
    else if (exc_req)              src = EXC;
    else if (eret_req)             src = ERET;
    else if (en && redirect_valid) src = REDIR;
    else if (en && pend_valid)     src = PEND;
    else if (en)                   src = SEQ;
  end

  // A redirect is only buffered when the PC is holding; any PC update empties the buffer.
  assign buf_load  = (src == HOLD) && redirect_valid;
  assign buf_clear = (src != HOLD);

  pc_redirect_buf #(
    .WIDTH(WIDTH)
  ) u_redirect_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .load_target(redirect_target),
    .clear      (buf_clear),
    .pend_valid (pend_valid),
    .pend_target(pend_target)
  );

  // The PC register itself; increments wrap modulo 2^WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_VEC;
    end else begin
      case (src)
        EXC:     pc_reg <= EXC_VEC;
        ERET:    pc_reg <= epc;
        REDIR:   pc_reg <= redirect_target;
        PEND:    pc_reg <= pend_target;
        SEQ:     pc_reg <= pc_plus_step;
        default: pc_reg <= pc_reg;
      endcase
    end
  end

  assign pc_out           = pc_reg;
  assign pc_plus_step     = pc_reg + WIDTH'(STEP);
  assign redirect_pending = pend_valid;
  assign adel             = (pc_reg[1:0] != 2'b00) || (pc_reg < IMEM_LO) || (pc_reg > IMEM_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with fixed expected
// PCs, followed by randomized traffic compared against a behavioural model.
module tb_pc_unit;

  localparam logic [31:0] T_RESET = 32'h0000_3000;
  localparam logic [31:0] T_EXC   = 32'h0000_4180;
  localparam logic [31:0] T_LO    = 32'h0000_3000;
  localparam logic [31:0] T_HI    = 32'h0000_6ffc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_step;
  logic        redirect_pending;
  logic        adel;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_pc = T_RESET;
  bit          m_pending = 1'b0;
  logic [31:0] m_pend_target = '0;

  pc_unit dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_req         (exc_req),
    .eret_req        (eret_req),
    .epc             (epc),
    .pc_out          (pc_out),
    .pc_plus_step    (pc_plus_step),
    .redirect_pending(redirect_pending),
    .adel            (adel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic bit modelAdel(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < T_LO) || (pc > T_HI);
  endfunction

  task automatic checkModel(input string tag);
    checkOutput({tag, ".pc"}, pc_out, m_pc);
    checkOutput({tag, ".pc4"}, pc_plus_step, m_pc + 32'd4);
    checkOutput({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, m_pending});
    checkOutput({tag, ".adel"}, {31'd0, adel}, {31'd0, modelAdel(m_pc)});
  endtask

  // Drive one cycle of inputs, advance the model by the priority rules, then compare.
  task automatic applyStimulus(input bit r, input bit e, input bit rv, input logic [31:0] rt,
                               input bit x, input bit er, input logic [31:0] ep, input string tag);
    reset = r; en = e; redirect_valid = rv; redirect_target = rt;
    exc_req = x; eret_req = er; epc = ep;
    if (r) begin
      m_pc = T_RESET; m_pending = 0; m_pend_target = '0;
    end else if (x) begin
      m_pc = T_EXC; m_pending = 0;
    end else if (er) begin
      m_pc = ep; m_pending = 0;
    end else if (e && rv) begin
      m_pc = rt; m_pending = 0;
    end else if (e && m_pending) begin
      m_pc = m_pend_target; m_pending = 0;
    end else if (e) begin
      m_pc = m_pc + 32'd4;
    end else if (rv) begin
      m_pending = 1; m_pend_target = rt;
    end
    @(posedge clk);
    #1;
    checkModel(tag);
  endtask

  initial begin
    #1;
    checkOutput("init_pc", pc_out, T_RESET);

    // Reset and sequential fetch
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "reset");
    checkOutput("reset_pc", pc_out, 32'h3000);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, "seq1");
    applyStimulus(0, 1, 0, 0, 0, 0, 0, "seq2");
    checkOutput("seq2_pc", pc_out, 32'h3008);
    applyStimulus(0, 1, 1, 32'h3100, 0, 0, 0, "redir");
    checkOutput("redir_pc", pc_out, 32'h3100);

    // Redirects during a stall; the later one wins
    applyStimulus(0, 1, 1, 32'h3010, 0, 0, 0, "to3010");
    applyStimulus(0, 0, 1, 32'h3200, 0, 0, 0, "stall1");
    checkOutput("stall1_pend", {31'd0, redirect_pending}, 32'd1);
    applyStimulus(0, 0, 1, 32'h3300, 0, 0, 0, "stall2");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "stall3");
    checkOutput("stall3_pc", pc_out, 32'h3010);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, "release");
    checkOutput("release_pc", pc_out, 32'h3300);

    // Exception discards the buffered redirect
    applyStimulus(0, 0, 1, 32'h3400, 0, 0, 0, "hold3400");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, "exc");
    checkOutput("exc_pc", pc_out, 32'h4180);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, "after_exc");
    checkOutput("after_exc_pc", pc_out, 32'h4184);

    // exc beats eret; eret alone returns to epc
    applyStimulus(0, 1, 0, 0, 1, 1, 32'h3020, "exc_eret");
    checkOutput("exc_eret_pc", pc_out, 32'h4180);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h3020, "eret");
    checkOutput("eret_pc", pc_out, 32'h3020);

    // Fetch address errors and bounds
    applyStimulus(0, 1, 1, 32'h3002, 0, 0, 0, "misalign");
    checkOutput("misalign_adel", {31'd0, adel}, 32'd1);
    applyStimulus(0, 1, 1, 32'h7000, 0, 0, 0, "above");
    checkOutput("above_adel", {31'd0, adel}, 32'd1);
    applyStimulus(0, 1, 1, 32'h6ffc, 0, 0, 0, "top_ok");
    checkOutput("top_ok_adel", {31'd0, adel}, 32'd0);
    applyStimulus(0, 1, 1, 32'h2ffc, 0, 0, 0, "below");
    checkOutput("below_adel", {31'd0, adel}, 32'd1);

    // Wrap-around of the increment
    applyStimulus(0, 1, 1, 32'hffff_fffc, 0, 0, 0, "wrap_pre");
    checkOutput("wrap_pc4", pc_plus_step, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, "wrap");
    checkOutput("wrap_pc", pc_out, 32'h0);

    // Reset while a redirect is held
    applyStimulus(0, 0, 1, 32'h3500, 0, 0, 0, "hold3500");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "reset_held");
    checkOutput("reset_held_pc", pc_out, 32'h3000);
    checkOutput("reset_held_pend", {31'd0, redirect_pending}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit          r, e, rv, x, er;
      logic [31:0] rt, ep;
      r  = ($urandom_range(0, 49) == 0);
      e  = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 3) == 0);
      x  = ($urandom_range(0, 19) == 0);
      er = ($urandom_range(0, 19) == 0);
      rt = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                       : 32'h3000 + 32'($urandom_range(0, 4095)) * 32'd4;
      ep = 32'h3000 + 32'($urandom_range(0, 4095)) * 32'd4;
      applyStimulus(r, e, rv, rt, x, er, ep, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
